rs_sec_decoder: RTL and testbench

RS_SEC_DECODER -- requirements
Module: rs_sec_decoder

---
 rtl/rs_sec_decoder.sv | 178 +++++++++++++++++
 tb/tb_rs_sec_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_sec_decoder.sv
// Single-symbol-correcting Reed-Solomon decoder (roots alpha, alpha^2) over GF(2^SYM_W).
// Define RS_SEC_DECODER_ERR_CNT_EN to add saturating fixed/uncorrectable event counters.
module rs_sec_decoder #(
    parameter int SYM_W     = 3,
    parameter int PRIM_POLY = 11,
    localparam int N        = (1 << SYM_W) - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*SYM_W-1:0]   codeword,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*SYM_W-1:0]   corrected,
    output logic                 err_fixed,
    output logic                 err_uncorr,
    output logic [SYM_W-1:0]     err_pos
`ifdef RS_SEC_DECODER_ERR_CNT_EN
    ,
    output logic [15:0]          fixed_cnt,
    output logic [15:0]          uncorr_cnt
`endif
);

    localparam int               CW_W    = N * SYM_W;
    localparam logic [SYM_W-1:0] POLY_LO = SYM_W'(PRIM_POLY);
    localparam logic [SYM_W-1:0] LAST    = SYM_W'(N);

    typedef enum logic [2:0] {IDLE, SYND, LOCATE, FIX, DONE} state_t;

    function automatic logic [SYM_W-1:0] mul_alpha(input logic [SYM_W-1:0] x);
        return {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? POLY_LO : '0);
    endfunction

    function automatic logic [SYM_W-1:0] mul_alpha2(input logic [SYM_W-1:0] x);
        return mul_alpha(mul_alpha(x));
    endfunction

    // Inverse of mul_alpha: an odd value had the reduction polynomial folded in.
    function automatic logic [SYM_W-1:0] div_alpha(input logic [SYM_W-1:0] x);
        logic [SYM_W-1:0] r;
        if (x[0]) begin
            r = (x ^ POLY_LO) >> 1;
            r[SYM_W-1] = 1'b1;
        end else begin
            r = x >> 1;
        end
        return r;
    endfunction

`ifdef RS_SEC_DECODER_ERR_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    state_t           state;
    logic [SYM_W-1:0] cnt;
    logic [CW_W-1:0]  cw_reg;
    logic [SYM_W-1:0] s1;
    logic [SYM_W-1:0] s2;
    logic [SYM_W-1:0] t_acc;
    logic [SYM_W-1:0] y_acc;
    logic             found;
    logic [SYM_W-1:0] loc_pos;
    logic [SYM_W-1:0] loc_val;

    logic [SYM_W-1:0] sym_k;
    logic [CW_W-1:0]  fix_mask;

    always_comb begin
        sym_k    = SYM_W'(cw_reg >> (int'(cnt) * SYM_W));
        fix_mask = CW_W'(loc_val) << (int'(loc_pos) * SYM_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            err_fixed  <= 1'b0;
            err_uncorr <= 1'b0;
            err_pos    <= '0;
            corrected  <= '0;
`ifdef RS_SEC_DECODER_ERR_CNT_EN
            fixed_cnt  <= '0;
            uncorr_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cw_reg   <= codeword;
                        s1       <= '0;
                        s2       <= '0;
                        cnt      <= SYM_W'(N - 1);
                        in_ready <= 1'b0;
                        state    <= SYND;
                    end
                end

                // ---- syndrome stage: Horner, highest-index symbol first
                SYND: begin
                    s1 <= mul_alpha(s1) ^ sym_k;
                    s2 <= mul_alpha2(s2) ^ sym_k;
                    if (cnt == '0) begin
                        state <= LOCATE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // ---- locate stage: cnt==0 seeds T/Y, cnt==j+1 tests position j
                LOCATE: begin
                    if (cnt == '0) begin
                        t_acc   <= s1;
                        y_acc   <= s1;
                        found   <= 1'b0;
                        loc_pos <= '0;
                        loc_val <= '0;
                    end else begin
                        if (!found && (t_acc == s2)) begin
                            found   <= 1'b1;
                            loc_pos <= cnt - 1'b1;
                            loc_val <= y_acc;
                        end
                        t_acc <= mul_alpha(t_acc);
                        y_acc <= div_alpha(y_acc);
                    end
                    if (cnt == LAST) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // ---- fix stage: classify and register the result
                FIX: begin
                    if ((s1 == '0) && (s2 == '0)) begin
                        corrected  <= cw_reg;
                        err_fixed  <= 1'b0;
                        err_uncorr <= 1'b0;
                        err_pos    <= '0;
                    end else if ((s1 != '0) && (s2 != '0) && found) begin
                        corrected  <= cw_reg ^ fix_mask;
                        err_fixed  <= 1'b1;
                        err_uncorr <= 1'b0;
                        err_pos    <= loc_pos;
                    end else begin
                        corrected  <= cw_reg;
                        err_fixed  <= 1'b0;
                        err_uncorr <= 1'b1;
                        err_pos    <= '0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
`ifdef RS_SEC_DECODER_ERR_CNT_EN
                        if (err_fixed) fixed_cnt <= sat_inc(fixed_cnt);
                        if (err_uncorr) uncorr_cnt <= sat_inc(uncorr_cnt);
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_sec_decoder.sv
// Randomised self-checking bench for rs_sec_decoder (SYM_W=3, PRIM_POLY=11) against a GF algebra model.
module tb_rs_sec_decoder;

    localparam int SYM_W = 3;
    localparam int POLY  = 11;
    localparam int N     = (1 << SYM_W) - 1;
    localparam int CW_W  = N * SYM_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   codeword;
    logic              out_valid;
    logic              out_ready;
    logic [CW_W-1:0]   corrected;
    logic              err_fixed;
    logic              err_uncorr;
    logic [SYM_W-1:0]  err_pos;
`ifdef RS_SEC_DECODER_ERR_CNT_EN
    logic [15:0]       fixed_cnt;
    logic [15:0]       uncorr_cnt;
`endif

    always #5 clk = ~clk;

    rs_sec_decoder #(.SYM_W(SYM_W), .PRIM_POLY(POLY)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .codeword(codeword),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .corrected(corrected),
        .err_fixed(err_fixed),
        .err_uncorr(err_uncorr),
        .err_pos(err_pos)
`ifdef RS_SEC_DECODER_ERR_CNT_EN
        ,
        .fixed_cnt(fixed_cnt),
        .uncorr_cnt(uncorr_cnt)
`endif
    );

    typedef struct {
        logic [CW_W-1:0]  corr;
        logic             fixed;
        logic             uncorr;
        logic [SYM_W-1:0] pos;
        int               acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   bp_left   = 0;
    bit   rnd_ready = 1'b0;
    int   exp_fcnt  = 0;
    int   exp_ucnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic int gf_mul(input int a, input int b);
        int p = 0;
        int x = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (((b >> i) & 1) != 0) p ^= x;
            x = x << 1;
            if ((x & (1 << SYM_W)) != 0) x ^= POLY;
        end
        return p;
    endfunction

    function automatic int apow(input int k);
        int r = 1;
        for (int i = 0; i < (k % N); i++) r = gf_mul(r, 2);
        return r;
    endfunction

    function automatic int sym(input logic [CW_W-1:0] cw, input int k);
        return int'(cw[k*SYM_W +: SYM_W]);
    endfunction

    // Returns {S1, S2} as S1 = sum c_k a^k, S2 = sum c_k a^2k.
    function automatic int syndromes(input logic [CW_W-1:0] cw);
        int s1 = 0;
        int s2 = 0;
        for (int k = 0; k < N; k++) begin
            s1 ^= gf_mul(sym(cw, k), apow(k));
            s2 ^= gf_mul(sym(cw, k), apow(2 * k));
        end
        return (s1 << SYM_W) | s2;
    endfunction

    // Decoder behaviour: the lowest position j admitting a nonzero error e that explains both syndromes.
    function automatic exp_t model(input logic [CW_W-1:0] cw);
        exp_t r;
        int   s;
        int   s1;
        int   s2;
        bit   hit = 1'b0;
        s  = syndromes(cw);
        s1 = s >> SYM_W;
        s2 = s & N;
        r.corr = cw; r.fixed = 1'b0; r.uncorr = 1'b0; r.pos = '0; r.acc = 0;
        if (s1 != 0 || s2 != 0) begin
            for (int j = 0; j < N; j++) begin
                for (int e = 1; e <= N; e++) begin
                    if (!hit && gf_mul(e, apow(j)) == s1 && gf_mul(e, apow(2 * j)) == s2) begin
                        hit = 1'b1;
                        r.pos = SYM_W'(j);
                        r.corr[j*SYM_W +: SYM_W] = cw[j*SYM_W +: SYM_W] ^ SYM_W'(e);
                    end
                end
            end
            r.fixed  = hit;
            r.uncorr = !hit;
        end
        return r;
    endfunction

    function automatic logic [CW_W-1:0] gen_valid();
        logic [CW_W-1:0] cw;
        bit done = 1'b0;
        cw = CW_W'($urandom);
        for (int p = 0; p < (N + 1) * (N + 1); p++) begin
            if (!done) begin
                cw[0 +: SYM_W]     = SYM_W'(p % (N + 1));
                cw[SYM_W +: SYM_W] = SYM_W'(p / (N + 1));
                if (syndromes(cw) == 0) done = 1'b1;
            end
        end
        return cw;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_left > 0) begin
                out_ready = 1'b0;
                if (out_valid) bp_left--;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    bit prev_valid = 1'b0;
    bit hs_pend    = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (hs_pend) begin
            chk("in_ready_after_handshake", in_ready, 1);
            chk("out_valid_after_handshake", out_valid, 0);
            hs_pend = 1'b0;
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                e = exp_q[0];
                if (!prev_valid) chk("latency", cyc - e.acc - 1, 2 * N + 2);
                chk("corrected", corrected, e.corr);
                chk("err_fixed", err_fixed, e.fixed);
                chk("err_uncorr", err_uncorr, e.uncorr);
                chk("err_pos", err_pos, e.pos);
                chk("in_ready_while_valid", in_ready, 0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    hs_pend = 1'b1;
                    if (e.fixed && exp_fcnt < 65535) exp_fcnt++;
                    if (e.uncorr && exp_ucnt < 65535) exp_ucnt++;
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [CW_W-1:0] cw);
        int   waitc = 0;
        exp_t e;
        in_valid = 1'b1;
        codeword = cw;
        @(negedge clk);
        while (!in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept_timeout", in_ready, 1);
        if (in_ready) begin
            e = model(cw);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        codeword = CW_W'($urandom);
    endtask

    task automatic wait_idle();
        int waitc = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && in_ready) && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_timeout", in_ready, 1);
    endtask

    initial begin
        exp_t            m;
        logic [CW_W-1:0] w;
        reset    = 1'b1;
        in_valid = 1'b0;
        codeword = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_fixed", err_fixed, 0);
        chk("rst_err_uncorr", err_uncorr, 0);
        chk("rst_err_pos", err_pos, 0);
        chk("rst_corrected", corrected, 0);

        // Hand-derived decodes pinning the model.
        m = model('0);
        chk("model_clean_fixed", m.fixed, 0);
        chk("model_clean_uncorr", m.uncorr, 0);
        w = '0; w[2*SYM_W +: SYM_W] = 3'b101;
        m = model(w);
        chk("model_single_fixed", m.fixed, 1);
        chk("model_single_pos", m.pos, 2);
        chk("model_single_corr", m.corr, 0);
        w = '0; w[0 +: SYM_W] = 3'b010; w[SYM_W +: SYM_W] = 3'b001;
        m = model(w);
        chk("model_uncorr_flag", m.uncorr, 1);
        chk("model_uncorr_corr", m.corr, w);
        @(posedge clk);
        #1;

        send('0);
        for (int p = 0; p < N; p++) begin
            for (int v = 1; v <= N; v++) begin
                w = '0;
                w[p*SYM_W +: SYM_W] = SYM_W'(v);
                send(w);
            end
        end
        w = '0; w[0 +: SYM_W] = 3'b010; w[SYM_W +: SYM_W] = 3'b001;
        send(w);

        // Backpressure: five cycles of out_ready low once out_valid is up.
        wait_idle();
        bp_left = 5;
        w = gen_valid();
        w[4*SYM_W +: SYM_W] = w[4*SYM_W +: SYM_W] ^ 3'b110;
        @(posedge clk);
        #1;
        send(w);
        wait_idle();

        // Reset ten cycles after accept, then a fresh word.
        @(posedge clk);
        #1;
        w = gen_valid();
        w[1*SYM_W +: SYM_W] = w[1*SYM_W +: SYM_W] ^ 3'b011;
        send(w);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_fcnt = 0;
        exp_ucnt = 0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        w = gen_valid();
        w[5*SYM_W +: SYM_W] = w[5*SYM_W +: SYM_W] ^ 3'b111;
        send(w);

        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int nerr;
            w    = gen_valid();
            nerr = $urandom_range(0, 2);
            for (int k = 0; k < nerr; k++) begin
                int p;
                p = $urandom_range(0, N - 1);
                w[p*SYM_W +: SYM_W] = w[p*SYM_W +: SYM_W] ^ SYM_W'($urandom_range(1, N));
            end
            send(w);
        end
        wait_idle();
        repeat (2) @(negedge clk);
`ifdef RS_SEC_DECODER_ERR_CNT_EN
        chk("fixed_cnt", fixed_cnt, exp_fcnt);
        chk("uncorr_cnt", uncorr_cnt, exp_ucnt);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
